// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_sign_adj.sv
// Combinational conditional two's-complement negate, used for operand abs and result sign fix.
// Only built when MULDIV_SIGNED_EN is defined.
`ifdef MULDIV_SIGNED_EN
module muldiv_sign_adj #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? -i_val : i_val;

endmodule
`endif

// File: rtl/mul_div_unit.sv
// Radix-2 iterative MUL/MULH/DIV/REM unit with valid/ready handshake on both sides.
// Define MULDIV_SIGNED_EN to honour i_signed (two's-complement via muldiv_sign_adj).
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WORD_SIZE     = 32,
  parameter int REG_ADDR_SIZE = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [1:0]               i_op,
  input  logic                     i_signed,
  input  logic [WORD_SIZE-1:0]     i_op_a,
  input  logic [WORD_SIZE-1:0]     i_op_b,
  input  logic [REG_ADDR_SIZE-1:0] i_wr_reg,
  input  logic                     i_flush,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WORD_SIZE-1:0]     o_result,
  output logic [REG_ADDR_SIZE-1:0] o_wr_reg
);

  localparam int W     = WORD_SIZE;
  localparam int CNT_W = $clog2(WORD_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_SIZE - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  op_e              op_q;
  logic [W-1:0]     opb_q;
  logic [2*W-1:0]   acc;
  logic [W:0]       rem;

  logic             accept;
  logic             div_zero;
  logic [W-1:0]     abs_a;
  logic [W-1:0]     abs_b;
  logic [W:0]       mul_sum;
  logic [2*W-1:0]   mul_next;
  logic             div_ge;
  logic [W-1:0]     div_trial;
  logic [W-1:0]     div_rem;
  logic [W-1:0]     div_quo;
  logic [W-1:0]     divres_raw;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     divres_fix;
  logic [W-1:0]     final_result;

  assign o_ready  = (state == ST_IDLE);
  assign accept   = i_valid && o_ready && !i_flush;
  assign div_zero = i_op[1] && (i_op_b == '0);

`ifdef MULDIV_SIGNED_EN
  logic neg_a;
  logic neg_b;
  logic neg_res_d;
  logic neg_res_q;

  assign neg_a     = i_signed & i_op_a[W-1];
  assign neg_b     = i_signed & i_op_b[W-1];
  // Remainder follows the dividend; product and quotient follow the sign difference.
  assign neg_res_d = (i_op == OP_REM) ? neg_a : (neg_a ^ neg_b);

  muldiv_sign_adj #(.WIDTH(W))   u_abs_a    (.i_val(i_op_a),     .i_neg(neg_a),     .o_val(abs_a));
  muldiv_sign_adj #(.WIDTH(W))   u_abs_b    (.i_val(i_op_b),     .i_neg(neg_b),     .o_val(abs_b));
  muldiv_sign_adj #(.WIDTH(2*W)) u_fix_prod (.i_val(mul_next),   .i_neg(neg_res_q), .o_val(prod_fix));
  muldiv_sign_adj #(.WIDTH(W))   u_fix_div  (.i_val(divres_raw), .i_neg(neg_res_q), .o_val(divres_fix));

  always_ff @(posedge i_clk) begin
    if (accept) neg_res_q <= neg_res_d;
  end
`else
  logic sign_unused;

  assign sign_unused = i_signed;
  assign abs_a       = i_op_a;
  assign abs_b       = i_op_b;
  assign prod_fix    = mul_next;
  assign divres_fix  = divres_raw;
`endif

  // Shift-add multiply step: low half of acc holds the remaining multiplier bits.
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, opb_q};
  assign mul_next = acc[0] ? {mul_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};

  // Restoring divide step: rem already holds the partial remainder with the next dividend bit shifted in.
  assign div_ge     = (rem >= {1'b0, opb_q});
  assign div_trial  = rem[W-1:0] - opb_q;
  assign div_rem    = div_ge ? div_trial : rem[W-1:0];
  assign div_quo    = {acc[W-2:0], div_ge};
  assign divres_raw = (op_q == OP_DIV) ? div_quo : div_rem;

  always_comb begin
    final_result = divres_fix;
    case (op_q)
      OP_MUL:  final_result = prod_fix[W-1:0];
      OP_MULH: final_result = prod_fix[2*W-1:W];
      default: final_result = divres_fix;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      op_q  <= op_e'(i_op);
      opb_q <= abs_b;
      if (i_op[1]) begin
        acc <= {{W{1'b0}}, abs_a[W-2:0], 1'b0};
        rem <= {{W{1'b0}}, abs_a[W-1]};
      end else begin
        acc <= {{W{1'b0}}, abs_a};
        rem <= '0;
      end
    end else if (state == ST_RUN) begin
      if (op_q[1]) begin
        acc[W-1:0] <= div_quo;
        rem        <= {div_rem, acc[W-1]};
      end else begin
        acc <= mul_next;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_wr_reg <= '0;
    end else if (i_flush) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            o_wr_reg <= i_wr_reg;
            cnt      <= '0;
            if (div_zero) begin
              o_result <= (i_op == OP_DIV) ? '1 : i_op_a;
              o_valid  <= 1'b1;
              state    <= ST_DONE;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            o_result <= final_result;
            o_valid  <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, corner sequences, random ops vs arithmetic model.
module tb_mul_div_unit;

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic        i_signed;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic [4:0]  i_wr_reg;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [4:0]  o_wr_reg;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  mul_div_unit #(.WORD_SIZE(32), .REG_ADDR_SIZE(5)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_signed (i_signed),
    .i_op_a   (i_op_a),
    .i_op_b   (i_op_b),
    .i_wr_reg (i_wr_reg),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_wr_reg (o_wr_reg)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Plain 64-bit arithmetic; SV '/' truncates toward zero and '%' takes the dividend's sign.
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic sgn,
                                            input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    bit     s;
    s  = sgn && SIGNED_EN;
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    p  = sa * sb;
    case (op)
      2'b00: return p[31:0];
      2'b01: return p[63:32];
      2'b10: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = sa % sb;
        return p[31:0];
      end
    endcase
  endfunction

  // Counts negedges after the accept edge until o_valid is seen; bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge i_clk);
      lat++;
    end while (!o_valid && lat < 100);
  endtask

  task automatic run_op(input logic [1:0] op, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        output logic [31:0] res, output logic [4:0] rtag, output int lat);
    @(negedge i_clk);
    i_valid  = 1'b1;
    i_op     = op;
    i_signed = sgn;
    i_op_a   = a;
    i_op_b   = b;
    i_wr_reg = tag;
    i_ready  = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    wait_valid(lat);
    res  = o_result;
    rtag = o_wr_reg;
    @(posedge i_clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] res;
  logic [4:0]  rtag;
  int          lat;
  int          seen;
  logic [1:0]  r_op;
  logic        r_sgn;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_tag;
  int          sel;

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_op = 2'b00; i_signed = 1'b0;
    i_op_a = '0; i_op_b = '0; i_wr_reg = '0; i_flush = 1'b0; i_ready = 1'b1;

    vecs.push_back('{"mul_7x6",      2'b00, 1'b0, 32'd7,         32'd6,         5'd5,  32'd42,        33});
    vecs.push_back('{"mulh_u_ones",  2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 33});
    vecs.push_back('{"mulh_s_ones",  2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,
                     SIGNED_EN ? 32'h0000_0000 : 32'hFFFF_FFFE, 33});
    vecs.push_back('{"mul_s_ones",   2'b00, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0001, 33});
    vecs.push_back('{"div_100_7",    2'b10, 1'b0, 32'd100,       32'd7,         5'd4,  32'd14,        33});
    vecs.push_back('{"rem_100_7",    2'b11, 1'b0, 32'd100,       32'd7,         5'd6,  32'd2,         33});
    vecs.push_back('{"div_s_m100_7", 2'b10, 1'b1, 32'hFFFF_FF9C, 32'd7,         5'd7,
                     SIGNED_EN ? 32'hFFFF_FFF2 : 32'h2492_4916, 33});
    vecs.push_back('{"rem_s_m100_7", 2'b11, 1'b1, 32'hFFFF_FF9C, 32'd7,         5'd8,
                     SIGNED_EN ? 32'hFFFF_FFFE : 32'h0000_0002, 33});
    vecs.push_back('{"div_s_ovf",    2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,
                     SIGNED_EN ? 32'h8000_0000 : 32'h0000_0000, 33});
    vecs.push_back('{"rem_s_ovf",    2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10,
                     SIGNED_EN ? 32'h0000_0000 : 32'h8000_0000, 33});
    vecs.push_back('{"div_by_zero",  2'b10, 1'b0, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1});
    vecs.push_back('{"rem_by_zero",  2'b11, 1'b0, 32'd5,         32'd0,         5'd12, 32'd5,         1});
    vecs.push_back('{"rem_s_neg_z",  2'b11, 1'b1, 32'hFFFF_FFFB, 32'd0,         5'd13, 32'hFFFF_FFFB, 1});
    vecs.push_back('{"mul_tag0",     2'b00, 1'b0, 32'h1234_5678, 32'h10,        5'd0,  32'h2345_6780, 33});
    vecs.push_back('{"mulh_s_m2x3",  2'b01, 1'b1, 32'hFFFF_FFFE, 32'd3,         5'd14,
                     SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0002, 33});

    repeat (2) @(negedge i_clk);
    chk("reset_valid",  {31'd0, o_valid}, 32'd0);
    chk("reset_ready",  {31'd0, o_ready}, 32'd1);
    chk("reset_result", o_result,         32'd0);
    chk("reset_tag",    {27'd0, o_wr_reg}, 32'd0);
    i_rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].tag, res, rtag, lat);
      chk({vecs[i].name, "_res"}, res, vecs[i].exp);
      chk({vecs[i].name, "_tag"}, {27'd0, rtag}, {27'd0, vecs[i].tag});
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
    end

    // Asynchronous reset ten cycles into a divide.
    @(negedge i_clk);
    i_valid = 1'b1; i_op = 2'b10; i_signed = 1'b0; i_op_a = 32'd1000; i_op_b = 32'd3; i_wr_reg = 5'd3;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    repeat (9) @(negedge i_clk);
    chk("pre_reset_busy", {31'd0, o_ready}, 32'd0);
    i_rst = 1'b1;
    #1;
    chk("midrun_reset_valid",  {31'd0, o_valid}, 32'd0);
    chk("midrun_reset_ready",  {31'd0, o_ready}, 32'd1);
    chk("midrun_reset_result", o_result,         32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    run_op(2'b10, 1'b0, 32'd9, 32'd3, 5'd4, res, rtag, lat);
    chk("post_reset_div_res", res, 32'd3);
    chk("post_reset_div_tag", {27'd0, rtag}, 32'd4);
    chk("post_reset_div_lat", 32'(lat), 32'd33);

    // Backpressure: result held for five cycles; a queued request waits for the handshake.
    @(negedge i_clk);
    i_ready = 1'b0;
    i_valid = 1'b1; i_op = 2'b00; i_signed = 1'b0; i_op_a = 32'd3; i_op_b = 32'd5; i_wr_reg = 5'd7;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'd33);
    i_valid = 1'b1; i_op_a = 32'd2; i_op_b = 32'd2; i_wr_reg = 5'd9;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_result", o_result,              32'd15);
      chk("bp_hold_tag",    {27'd0, o_wr_reg},     32'd7);
      chk("bp_hold_valid",  {31'd0, o_valid},      32'd1);
      chk("bp_hold_ready",  {31'd0, o_ready},      32'd0);
      @(negedge i_clk);
    end
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("bp_after_hs_valid", {31'd0, o_valid}, 32'd0);
    chk("bp_after_hs_ready", {31'd0, o_ready}, 32'd1);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    wait_valid(lat);
    chk("bp_next_res", o_result, 32'd4);
    chk("bp_next_tag", {27'd0, o_wr_reg}, 32'd9);
    chk("bp_next_lat", 32'(lat), 32'd33);
    @(posedge i_clk);

    // Flush four cycles into RUN: back to IDLE, no result.
    @(negedge i_clk);
    i_valid = 1'b1; i_op = 2'b00; i_op_a = 32'd11; i_op_b = 32'd13; i_wr_reg = 5'd15;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    @(negedge i_clk);
    chk("flush_run_ready", {31'd0, o_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_valid) seen++;
    end
    chk("flush_run_no_valid", 32'(seen), 32'd0);

    // Flush together with a request in IDLE: request is dropped.
    @(negedge i_clk);
    i_valid = 1'b1; i_flush = 1'b1; i_op = 2'b10; i_op_a = 32'd8; i_op_b = 32'd0;
    @(posedge i_clk);
    #1 begin i_valid = 1'b0; i_flush = 1'b0; end
    @(negedge i_clk);
    chk("flush_idle_ready", {31'd0, o_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_valid) seen++;
    end
    chk("flush_idle_no_valid", 32'(seen), 32'd0);

    // Randomized ops against the arithmetic model, biased toward corner operands.
    for (int n = 0; n < 40; n++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_sgn = 1'($urandom_range(0, 1));
      r_a   = $urandom;
      r_b   = $urandom;
      r_tag = 5'($urandom_range(0, 31));
      sel   = $urandom_range(0, 7);
      case (sel)
        0: r_b = 32'd0;
        1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2: begin r_a = 32'($urandom_range(0, 255)); r_b = 32'($urandom_range(1, 15)); end
        3: r_b = 32'($urandom_range(1, 3));
        default: ;
      endcase
      run_op(r_op, r_sgn, r_a, r_b, r_tag, res, rtag, lat);
      chk("rand_res", res, ref_model(r_op, r_sgn, r_a, r_b));
      chk("rand_tag", {27'd0, rtag}, {27'd0, r_tag});
      chk("rand_lat", 32'(lat), (r_op[1] && r_b == 32'd0) ? 32'd1 : 32'd33);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
